// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller and the ALU decoder.
package mips_ctrl_pkg;

  // Opcode field values for the supported instruction subset
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // alu_op encodings understood by the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B mux selects
  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  // Next-PC mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  // True when the opcode belongs to the implemented subset
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles and raises a sticky error
// once the wait reaches MEM_TIMEOUT. MEM_TIMEOUT of 0 disables the flag.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_timeout
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            waiting;

  assign waiting = mem_req & ~mem_ready;

  // Wait counter: clears whenever no wait is in progress, saturates at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!waiting) begin
      wait_cnt <= '0;
    end else if (wait_cnt != LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error: set on the edge where the count arrives at the limit, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout <= 1'b0;
    end else if ((MEM_TIMEOUT != 0) && waiting && (wait_cnt == LAST)) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback
// and drives all datapath enables, mux selects and the ALU decoder's alu_op.
module mc_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t state;
  logic   pc_write;
  logic   branch;

  // State register and next-state rules; op only matters in DECODE and MEMADR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWB:   state <= S_FETCH;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= S_ALUWB;
        S_ALUWB:   state <= S_FETCH;
        S_BRANCH:  state <= S_FETCH;
        S_ADDIEX:  state <= S_ADDIWB;
        S_ADDIWB:  state <= S_FETCH;
        S_JUMP:    state <= S_FETCH;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Output decode of the current state; only FETCH's load strobes look at mem_ready
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SHL2;
        illegal_op = ~op_supported(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign pc_en = pc_write | (branch & zero);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_mem_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .mem_timeout(mem_timeout)
  );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for mc_main_ctrl built with a short timeout limit.
module tb_mc_main_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, ir_write, reg_write, mem_req, mem_write, i_or_d;
  logic       mem_to_reg, reg_dst, alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_src, alu_op;

  int checkCount = 0;
  int passCount  = 0;

  // Expected output bundles, field order:
  // {pc_en, ir_write, reg_write, mem_req, mem_write, i_or_d, mem_to_reg, reg_dst,
  //  alu_src_a, alu_src_b[1:0], pc_src[1:0], alu_op[1:0], illegal_op, mem_timeout}
  localparam logic [16:0] E_IDLE    = 17'b000000000_00_00_00_0_0;
  localparam logic [16:0] E_FETCH   = 17'b110100000_01_00_00_0_0;
  localparam logic [16:0] E_FWAIT   = 17'b000100000_01_00_00_0_0;
  localparam logic [16:0] E_DECODE  = 17'b000000000_11_00_00_0_0;
  localparam logic [16:0] E_DEC_ILL = 17'b000000000_11_00_00_1_0;
  localparam logic [16:0] E_MEMADR  = 17'b000000001_10_00_00_0_0;
  localparam logic [16:0] E_MEMRD   = 17'b000101000_00_00_00_0_0;
  localparam logic [16:0] E_MEMWB   = 17'b001000100_00_00_00_0_0;
  localparam logic [16:0] E_MEMWR   = 17'b000111000_00_00_00_0_0;
  localparam logic [16:0] E_EXEC    = 17'b000000001_00_00_10_0_0;
  localparam logic [16:0] E_ALUWB   = 17'b001000010_00_00_00_0_0;
  localparam logic [16:0] E_BR_T    = 17'b100000001_00_01_01_0_0;
  localparam logic [16:0] E_BR_N    = 17'b000000001_00_01_01_0_0;
  localparam logic [16:0] E_ADDIWB  = 17'b001000000_00_00_00_0_0;
  localparam logic [16:0] E_JUMP    = 17'b100000000_00_10_00_0_0;
  localparam logic [16:0] TO        = 17'b000000000_00_00_00_0_1;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  mc_main_ctrl #(
    .MEM_TIMEOUT(4),
    .TO_W       (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the whole output bundle against an expected value
  task automatic checkOutput(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {pc_en, ir_write, reg_write, mem_req, mem_write, i_or_d, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_op, illegal_op, mem_timeout};
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Drive one cycle's inputs on the falling edge and check the outputs just after
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    op        = v.op;
    zero      = v.zero;
    mem_ready = v.rdy;
    #1;
    checkOutput(v.name, v.exp);
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] o, input logic z,
                              input logic r, input logic [16:0] e);
    vec_t v;
    v.name = n; v.op = o; v.zero = z; v.rdy = r; v.exp = e;
    return v;
  endfunction

  initial begin
    // LW with zero-wait memory
    vecs.push_back(mk("lw_fetch",   LW, 0, 1, E_FETCH));
    vecs.push_back(mk("lw_decode",  LW, 0, 1, E_DECODE));
    vecs.push_back(mk("lw_memadr",  LW, 0, 1, E_MEMADR));
    vecs.push_back(mk("lw_memrd",   LW, 0, 1, E_MEMRD));
    vecs.push_back(mk("lw_memwb",   LW, 0, 1, E_MEMWB));
    // R-type
    vecs.push_back(mk("rt_fetch",   RT, 0, 1, E_FETCH));
    vecs.push_back(mk("rt_decode",  RT, 0, 1, E_DECODE));
    vecs.push_back(mk("rt_execute", RT, 0, 1, E_EXEC));
    vecs.push_back(mk("rt_aluwb",   RT, 0, 1, E_ALUWB));
    // BEQ taken, then not taken
    vecs.push_back(mk("beqt_fetch", BEQ, 0, 1, E_FETCH));
    vecs.push_back(mk("beqt_decode",BEQ, 0, 1, E_DECODE));
    vecs.push_back(mk("beqt_branch",BEQ, 1, 1, E_BR_T));
    vecs.push_back(mk("beqn_fetch", BEQ, 0, 1, E_FETCH));
    vecs.push_back(mk("beqn_decode",BEQ, 0, 1, E_DECODE));
    vecs.push_back(mk("beqn_branch",BEQ, 0, 1, E_BR_N));
    // ADDI
    vecs.push_back(mk("addi_fetch", ADDI, 0, 1, E_FETCH));
    vecs.push_back(mk("addi_decode",ADDI, 0, 1, E_DECODE));
    vecs.push_back(mk("addi_ex",    ADDI, 0, 1, E_MEMADR));
    vecs.push_back(mk("addi_wb",    ADDI, 0, 1, E_ADDIWB));
    // J
    vecs.push_back(mk("j_fetch",    JMP, 0, 1, E_FETCH));
    vecs.push_back(mk("j_decode",   JMP, 0, 1, E_DECODE));
    vecs.push_back(mk("j_jump",     JMP, 0, 1, E_JUMP));
    // Illegal opcode, then back to FETCH (op in FETCH is ignored)
    vecs.push_back(mk("bad_fetch",  BAD, 0, 1, E_FETCH));
    vecs.push_back(mk("bad_decode", BAD, 0, 1, E_DEC_ILL));
    vecs.push_back(mk("bad_refetch",SW,  0, 1, E_FETCH));
    // SW with three wait cycles in MEMWR
    vecs.push_back(mk("sw_decode",  SW, 0, 1, E_DECODE));
    vecs.push_back(mk("sw_memadr",  SW, 0, 1, E_MEMADR));
    vecs.push_back(mk("sw_wait1",   SW, 0, 0, E_MEMWR));
    vecs.push_back(mk("sw_wait2",   SW, 0, 0, E_MEMWR));
    vecs.push_back(mk("sw_wait3",   SW, 0, 0, E_MEMWR));
    vecs.push_back(mk("sw_ready",   SW, 0, 1, E_MEMWR));
    // Fetch stall long enough to trip the 4-cycle timeout
    vecs.push_back(mk("to_wait1",   LW, 0, 0, E_FWAIT));
    vecs.push_back(mk("to_wait2",   LW, 0, 0, E_FWAIT));
    vecs.push_back(mk("to_wait3",   LW, 0, 0, E_FWAIT));
    vecs.push_back(mk("to_wait4",   LW, 0, 0, E_FWAIT));
    vecs.push_back(mk("to_flagged", LW, 0, 0, E_FWAIT | TO));
    vecs.push_back(mk("to_release", LW, 0, 1, E_FETCH | TO));
    vecs.push_back(mk("to_decode",  LW, 0, 1, E_DECODE | TO));
    vecs.push_back(mk("to_memadr",  LW, 0, 1, E_MEMADR | TO));
    vecs.push_back(mk("to_memrd_wait", LW, 0, 0, E_MEMRD | TO));

    op        = LW;
    zero      = 1'b0;
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    checkOutput("reset_assert", E_IDLE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_idle", E_IDLE);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset while waiting in MEMRD: outputs and the sticky flag drop with no clock edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_memrd", E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_after_reset", E_IDLE);
    applyStimulus(mk("fetch_after_reset", LW, 0, 1, E_FETCH));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multicycle main controller FSM. Sequences fetch/decode/execute/memory/writeback for the supported MIPS subset.
- Sits directly upstream of the ALU decoder: drives its alu_op (00 add, 01 sub, 10 funct-decode) plus all datapath enables and muxes.
- Supports variable-latency memory through a req/ready handshake and a wait-timeout monitor.

Parameters:
- MEM_TIMEOUT, 255: max cycles mem_req may stay unacknowledged before mem_timeout sets. 0 disables the monitor.
- TO_W, 8: timeout counter width. Must satisfy 2**TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- pc_en  out  1  PC load = pc_write | (branch & zero)
- ir_write  out  1  load instruction register
- reg_write  out  1  register file write
- mem_req  out  1  memory access request
- mem_write  out  1  access is a store; valid only with mem_req
- i_or_d  out  1  address mux: 0 = PC, 1 = ALUOut
- mem_to_reg  out  1  writeback mux: 1 = memory data
- reg_dst  out  1  destination: 1 = rd, 0 = rt
- alu_src_a  out  1  0 = PC, 1 = regA
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_op  out  2  to ALU decoder
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- mem_timeout  out  1  sticky timeout error

Behaviour:
- Reset: state = IDLE. mem_timeout = 0 and the counter = 0. Every output is 0 while in IDLE.
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Outputs are a combinational decode of the state. Exception: ir_write and pc_write in FETCH are also gated by mem_ready.
- Any output not listed for a state is 0.
- States, their outputs, and next-state rules:
  - IDLE: all outputs 0. Next: FETCH, unconditionally.
  - FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. If mem_ready: ir_write=1, pc_write=1, next DECODE. Otherwise hold.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next by op:
    - LW or SW: MEMADR
    - RTYPE: EXECUTE
    - BEQ: BRANCH
    - ADDI: ADDIEX
    - J: JUMP
    - other: pulse illegal_op for one cycle, then FETCH
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for LW, MEMWR for SW.
  - MEMRD: mem_req=1, i_or_d=1. If mem_ready: MEMWB. Otherwise hold.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
  - MEMWR: mem_req=1, mem_write=1, i_or_d=1. If mem_ready: FETCH. Otherwise hold.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1. Next: FETCH.
- Latency with zero-wait memory (mem_ready held high):
  - LW: 5 cycles
  - SW, RTYPE, ADDI: 4 cycles
  - BEQ, J: 3 cycles
- Handshake rules:
  - mem_req, mem_write and i_or_d stay stable until the cycle in which mem_ready is seen.
  - mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Timeout monitor:
  - The counter increments each cycle with mem_req=1 and mem_ready=0. It clears on mem_ready or when mem_req=0.
  - When the counter reaches MEM_TIMEOUT, mem_timeout sets. It clears only on reset.
  - The FSM keeps waiting after a timeout; it does not abort the access.
  - The counter saturates; it never wraps.
- Reset mid-operation: asynchronous return to IDLE; all outputs drop immediately. An in-flight store is abandoned; mem_req drops with reset.
- op is sampled only in DECODE and MEMADR; changes in other states have no effect.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with the ALU decoder
  - alu_src_b and pc_src mux encodings
  - the state enum, 4 bits
- One sub-module: mem_wait_timer (counter plus sticky flag). The FSM stays in the top module.

Test Plan:
- Reset then mem_ready=1, op=100011 (LW) -> state sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 6; the next instruction's fetch starts at cycle 7.
- op=000000 (R-type) -> alu_op=10 only in EXECUTE. ALUWB shows reg_dst=1, reg_write=1. alu_op=00 in FETCH and DECODE.
- op=000100 (BEQ): with zero=1 -> pc_en=1 in BRANCH with pc_src=01. With zero=0 -> pc_en=0 and the FSM returns to FETCH.
- SW with mem_ready held low 3 cycles in MEMWR -> mem_req, mem_write and i_or_d stay 1 for 4 cycles; FETCH follows the ready cycle. mem_timeout stays 0.
- MEM_TIMEOUT=4 with mem_ready held low in FETCH -> mem_timeout=1 after 4 wait cycles, ir_write stays 0. Releasing mem_ready resumes normal flow; mem_timeout stays 1 until rst_n=0.
- op=111111 -> illegal_op pulses 1 cycle after DECODE, then FETCH with no reg_write or mem_req. Asserting rst_n=0 during a MEMRD wait -> all outputs 0 without a clock edge.
